// File: rtl/multicycle_control.sv
// multicycle_control: control FSM for a multi-cycle MIPS datapath with a
// shared ALU, a single memory port and a variable-latency memory handshake.
//
// Ports:
//   clk, rst_n         clock, asynchronous active-low reset
//   Opcode             IR[31:26], valid from DECODE onward
//   Zero, AluResMsb    ALU flags for branch evaluation
//   mem_ready          memory completes the current request this cycle
//   PCWr, PCSrc        PC write enable / source select
//   IorD, MemRd, MemWr memory address select and requests
//   IRWr               instruction register load
//   RegDst, RegWr,
//   MemtoReg           register file write controls
//   ExtOp, AluSrcA,
//   AluSrcB, AluOp     ALU operand / operation controls
//   instr_done         one-cycle pulse when an instruction retires
//   fault              00 none, 01 illegal opcode, 10 memory timeout (sticky)
module multicycle_control #(
    parameter int MEM_TIMEOUT = 16,
    parameter int CNT_W       = 5
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic [5:0] Opcode,
    input  logic       Zero,
    input  logic       AluResMsb,
    input  logic       mem_ready,
    output logic       PCWr,
    output logic [1:0] PCSrc,
    output logic       IorD,
    output logic       MemRd,
    output logic       MemWr,
    output logic       IRWr,
    output logic       RegDst,
    output logic       RegWr,
    output logic       MemtoReg,
    output logic       ExtOp,
    output logic       AluSrcA,
    output logic [1:0] AluSrcB,
    output logic [1:0] AluOp,
    output logic       instr_done,
    output logic [1:0] fault
);

    localparam logic [5:0] OP_R    = 6'b000000;
    localparam logic [5:0] OP_ADDI = 6'b001000;
    localparam logic [5:0] OP_LW   = 6'b100011;
    localparam logic [5:0] OP_SW   = 6'b101011;
    localparam logic [5:0] OP_BEQ  = 6'b000100;
    localparam logic [5:0] OP_BNE  = 6'b000101;
    localparam logic [5:0] OP_BGTZ = 6'b000111;

    localparam logic [1:0] F_NONE    = 2'b00;
    localparam logic [1:0] F_ILLEGAL = 2'b01;
    localparam logic [1:0] F_TIMEOUT = 2'b10;

    // Last wait count still allowed; a miss here times out.
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(MEM_TIMEOUT - 1);

    typedef enum logic [3:0] {
        S_FETCH,
        S_DECODE,
        S_EXEC_R,
        S_WB_R,
        S_EXEC_I,
        S_WB_I,
        S_ADDR,
        S_MEM_RD,
        S_WB_MEM,
        S_MEM_WR,
        S_BRANCH,
        S_HALT
    } state_t;

    state_t           state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [1:0]       fault_q, fault_d;

    // Next-state, wait counter and fault logic
    always_comb begin
        state_d = state_q;
        cnt_d   = '0;
        fault_d = fault_q;
        unique case (state_q)
            S_FETCH, S_MEM_RD, S_MEM_WR: begin
                if (mem_ready) begin
                    unique case (state_q)
                        S_FETCH:  state_d = S_DECODE;
                        S_MEM_RD: state_d = S_WB_MEM;
                        default:  state_d = S_FETCH;
                    endcase
                end else if (cnt_q == CNT_LAST) begin
                    state_d = S_HALT;
                    fault_d = F_TIMEOUT;
                end else begin
                    cnt_d = cnt_q + CNT_W'(1);
                end
            end
            S_DECODE: begin
                unique case (Opcode)
                    OP_R:    state_d = S_EXEC_R;
                    OP_ADDI: state_d = S_EXEC_I;
                    OP_LW,
                    OP_SW:   state_d = S_ADDR;
                    OP_BEQ,
                    OP_BNE,
                    OP_BGTZ: state_d = S_BRANCH;
                    default: begin
                        state_d = S_HALT;
                        fault_d = F_ILLEGAL;
                    end
                endcase
            end
            S_EXEC_R: state_d = S_WB_R;
            S_EXEC_I: state_d = S_WB_I;
            S_ADDR:   state_d = (Opcode == OP_SW) ? S_MEM_WR : S_MEM_RD;
            S_WB_R,
            S_WB_I,
            S_WB_MEM,
            S_BRANCH: state_d = S_FETCH;
            S_HALT:   state_d = S_HALT;
            default:  state_d = S_HALT;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= S_FETCH;
            cnt_q   <= '0;
            fault_q <= F_NONE;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            fault_q <= fault_d;
        end
    end

    // Outputs decode from state; PCWr/IRWr/instr_done have Mealy terms.
    // Holding rst_n low forces every enable off without waiting for a clock.
    always_comb begin
        PCWr       = 1'b0;
        PCSrc      = 2'b00;
        IorD       = 1'b0;
        MemRd      = 1'b0;
        MemWr      = 1'b0;
        IRWr       = 1'b0;
        RegDst     = 1'b0;
        RegWr      = 1'b0;
        MemtoReg   = 1'b0;
        ExtOp      = 1'b0;
        AluSrcA    = 1'b0;
        AluSrcB    = 2'b00;
        AluOp      = 2'b00;
        instr_done = 1'b0;
        if (rst_n) begin
            unique case (state_q)
                S_FETCH: begin
                    MemRd   = 1'b1;
                    AluSrcB = 2'b01;
                    IRWr    = mem_ready;
                    PCWr    = mem_ready;
                end
                S_DECODE: begin
                    AluSrcB = 2'b11;
                    ExtOp   = 1'b1;
                end
                S_EXEC_R: begin
                    AluSrcA = 1'b1;
                    AluOp   = 2'b10;
                end
                S_WB_R: begin
                    RegDst     = 1'b1;
                    RegWr      = 1'b1;
                    instr_done = 1'b1;
                end
                S_EXEC_I, S_ADDR: begin
                    AluSrcA = 1'b1;
                    AluSrcB = 2'b10;
                    ExtOp   = 1'b1;
                end
                S_WB_I: begin
                    RegWr      = 1'b1;
                    instr_done = 1'b1;
                end
                S_MEM_RD: begin
                    MemRd = 1'b1;
                    IorD  = 1'b1;
                end
                S_WB_MEM: begin
                    RegWr      = 1'b1;
                    MemtoReg   = 1'b1;
                    instr_done = 1'b1;
                end
                S_MEM_WR: begin
                    MemWr      = 1'b1;
                    IorD       = 1'b1;
                    instr_done = mem_ready;
                end
                S_BRANCH: begin
                    AluSrcA    = 1'b1;
                    AluOp      = 2'b01;
                    PCSrc      = 2'b01;
                    instr_done = 1'b1;
                    unique case (Opcode)
                        OP_BEQ:  PCWr = Zero;
                        OP_BNE:  PCWr = !Zero;
                        OP_BGTZ: PCWr = !Zero && !AluResMsb;
                        default: PCWr = 1'b0;
                    endcase
                end
                default: ;
            endcase
        end
    end

    assign fault = fault_q;

endmodule
